// File: rtl/vc_rr_scheduler_pkg.sv
// Shared definitions for the VC round-robin scheduler: word field layout,
// FSM state encodings and a small one-hot helper.
package vc_rr_scheduler_pkg;

    localparam int VC_WORD_SIZE = 12;
    localparam int VC_CLASS_LSB = 10;
    localparam int VC_DEST_LSB  = 8;
    localparam int VC_DEST_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/vc_rr_scheduler_rr_pick4.sv
// Combinational 4-way round-robin pick: first requester after 'last', wrapping,
// with 'last' itself checked last.
module rr_pick4
    import vc_rr_scheduler_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic       gnt_valid_o,
    output logic [1:0] gnt_id_o
);

    logic [1:0] idx;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = last_i;
        idx         = last_i;
        for (int k = 1; k <= 4; k++) begin
            idx = last_i + 2'(k);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = idx;
            end
        end
    end

endmodule

// File: rtl/vc_rr_scheduler.sv
// Round-robin scheduler moving head words from 4 VC input FIFOs to 4 output FIFOs.
// state | meaning:  IDLE | no pops  ;  RUN | arbitrating  ;  DRAIN | last push completing
module vc_rr_scheduler
    import vc_rr_scheduler_pkg::*;
#(
    parameter int WORD_SIZE = VC_WORD_SIZE,
    parameter int DEST_LSB  = VC_DEST_LSB,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [3:0]             in_empty,
    input  logic [4*WORD_SIZE-1:0] in_data,
    output logic [3:0]             in_pop,
    input  logic [3:0]             out_almost_full,
    output logic [3:0]             out_push,
    output logic [WORD_SIZE-1:0]   out_data,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       fwd_count
);

    sched_state_t         state_q, state_d;
    logic [3:0]           push_q, push_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [1:0]           last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 arb_en;
    logic [3:0]           req;
    logic                 gnt_valid;
    logic [1:0]           gnt_id;
    logic [WORD_SIZE-1:0] gnt_word;

    // enable gates requests directly, so no grant happens in the cycle it drops
    assign arb_en = (state_q == ST_RUN) && enable;

    always_comb begin
        req = '0;
        for (int i = 0; i < 4; i++) begin
            req[i] = arb_en && !in_empty[i]
                     && !out_almost_full[in_data[i*WORD_SIZE+DEST_LSB +: VC_DEST_W]];
        end
    end

    rr_pick4 u_pick (
        .req_i       (req),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign gnt_word = in_data[int'(gnt_id)*WORD_SIZE +: WORD_SIZE];

    always_comb begin
        state_d = state_q;
        push_d  = '0;
        data_d  = data_q;
        last_d  = last_q;
        in_pop  = '0;
        cnt_d   = cnt_q + ((push_q != '0) ? CNT_W'(1) : '0);

        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = (push_q != '0) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: state_d = enable ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (gnt_valid) begin
            in_pop = onehot4(gnt_id);
            push_d = onehot4(gnt_word[DEST_LSB +: VC_DEST_W]);
            data_d = gnt_word;
            last_d = gnt_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            push_q  <= '0;
            data_q  <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_push  = push_q;
    assign out_data  = data_q;
    assign grant_id  = last_q;
    assign fwd_count = cnt_q;
    assign busy      = (state_q == ST_RUN) || (push_q != '0);

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// Self-checking bench for vc_rr_scheduler (CNT_W=4 build so the counter wrap is reachable).
module tb_vc_rr_scheduler;

    localparam int W  = 12;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [3:0]      in_empty;
    logic [4*W-1:0]  in_data;
    logic [3:0]      in_pop;
    logic [3:0]      out_almost_full;
    logic [3:0]      out_push;
    logic [W-1:0]    out_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic [CW-1:0]   fwd_count;

    vc_rr_scheduler #(.WORD_SIZE(W), .DEST_LSB(8), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant_id        (grant_id),
        .busy            (busy),
        .fwd_count       (fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   push;
        logic [W-1:0] data;
        logic [1:0]   id;
    } exp_t;

    typedef struct packed {
        logic [3:0] empty;
        logic [7:0] dests;
        logic [3:0] afull;
        logic [3:0] exp_pop;
    } vec_t;

    exp_t         sb[$];
    vec_t         vecs[9];
    logic [W-1:0] fmem[4][16];
    int           fhead[4];
    int           fcnt[4];
    int           checks = 0;
    int           failures = 0;
    int           extra_push = 0;
    logic [CW-1:0] model_cnt;
    logic [CW-1:0] seen_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input int cls, input int dest, input int d);
        mk = {2'(cls), 2'(dest), 8'(d)};
    endfunction

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) begin
            fhead[i] = 0;
            fcnt[i]  = 0;
        end
    endtask

    task automatic load(input int i, input logic [W-1:0] w);
        fmem[i][(fhead[i] + fcnt[i]) % 16] = w;
        fcnt[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_empty[i]     = (fcnt[i] == 0);
            in_data[i*W +: W] = (fcnt[i] == 0) ? '0 : fmem[i][fhead[i]];
        end
    endtask

    task automatic sb_reset();
        exp_t e;
        e.push = '0;
        e.data = '0;
        e.id   = 2'd3;
        sb.delete();
        sb.push_back(e);
        model_cnt = '0;
    endtask

    // One clock: compare combinational pop and registered outputs, queue next expectation.
    task automatic tick(input logic [3:0] exp_pop, input int exp_busy);
        exp_t         cur;
        exp_t         nxt;
        int           g;
        logic [W-1:0] w;
        @(negedge clk);
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow actual=0 required=1 at %0t", $time);
            cur = '0;
        end else begin
            cur = sb.pop_front();
        end
        check("in_pop",    32'(in_pop),    32'(exp_pop));
        check("out_push",  32'(out_push),  32'(cur.push));
        check("out_data",  32'(out_data),  32'(cur.data));
        check("grant_id",  32'(grant_id),  32'(cur.id));
        check("fwd_count", 32'(fwd_count), 32'(model_cnt));
        if (exp_busy >= 0) check("busy", 32'(busy), 32'(exp_busy));
        seen_cnt = fwd_count;
        if (!enable && out_push != '0) extra_push++;
        nxt      = cur;
        nxt.push = '0;
        g        = -1;
        for (int i = 0; i < 4; i++) if (exp_pop[i]) g = i;
        if (g >= 0) begin
            w        = fmem[g][fhead[g]];
            nxt.push = 4'b0001 << w[9:8];
            nxt.data = w;
            nxt.id   = 2'(g);
        end
        sb.push_back(nxt);
        @(posedge clk);
        if (cur.push != '0) model_cnt = model_cnt + CW'(1);
        if (g >= 0) begin
            fhead[g] = (fhead[g] + 1) % 16;
            fcnt[g]--;
        end
        #1;
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rows run back-to-back in RUN; pointer enters at 3
        vecs[0] = '{empty:4'b1100, dests:{2'd0,2'd0,2'd0,2'd2}, afull:4'b0100, exp_pop:4'b0010};
        vecs[1] = '{empty:4'b1110, dests:{2'd0,2'd0,2'd0,2'd2}, afull:4'b0000, exp_pop:4'b0001};
        vecs[2] = '{empty:4'b0000, dests:{2'd3,2'd3,2'd3,2'd3}, afull:4'b0000, exp_pop:4'b0010};
        vecs[3] = '{empty:4'b0000, dests:{2'd0,2'd3,2'd3,2'd3}, afull:4'b1000, exp_pop:4'b1000};
        vecs[4] = '{empty:4'b1111, dests:{2'd0,2'd0,2'd0,2'd0}, afull:4'b0000, exp_pop:4'b0000};
        vecs[5] = '{empty:4'b0111, dests:{2'd2,2'd0,2'd0,2'd0}, afull:4'b0000, exp_pop:4'b1000};
        vecs[6] = '{empty:4'b0000, dests:{2'd1,2'd2,2'd3,2'd0}, afull:4'b1111, exp_pop:4'b0000};
        vecs[7] = '{empty:4'b1011, dests:{2'd0,2'd1,2'd0,2'd0}, afull:4'b1101, exp_pop:4'b0100};
        vecs[8] = '{empty:4'b0101, dests:{2'd0,2'd0,2'd0,2'd0}, afull:4'b0000, exp_pop:4'b1000};

        reset = 1'b1;
        enable = 1'b0;
        out_almost_full = '0;
        clear_fifos();
        for (int i = 0; i < 4; i++) load(i, mk(i, i, 8'hA0 + i));
        drive();
        sb_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state held with enable low
        repeat (5) tick(4'b0000, 0);

        // strict rotation, all to destination 1
        clear_fifos();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) load(i, mk(i, 1, 16*r + i));
        enable = 1'b1;
        drive();
        tick(4'b0000, 0);
        for (int k = 0; k < 8; k++) tick(4'b0001 << (k % 4), 1);
        tick(4'b0000, 1);
        tick(4'b0000, 1);
        check("fwd_count_after_stream", 32'(seen_cnt), 32'd8);

        // arbitration table
        for (int r = 0; r < 9; r++) begin
            clear_fifos();
            for (int i = 0; i < 4; i++)
                if (!vecs[r].empty[i]) load(i, mk(i, int'(vecs[r].dests[2*i +: 2]), 8'h40 + r*4 + i));
            out_almost_full = vecs[r].afull;
            drive();
            tick(vecs[r].exp_pop, 1);
        end
        out_almost_full = '0;

        // enable drop mid-stream
        clear_fifos();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) load(i, mk(i, 2, 8'h80 + r*4 + i));
        drive();
        extra_push = 0;
        for (int k = 0; k < 5; k++) tick(4'b0001 << (k % 4), 1);
        enable = 1'b0;
        tick(4'b0000, 1);
        tick(4'b0000, 0);
        tick(4'b0000, 0);
        check("drain_extra_push", 32'(extra_push), 32'd1);

        // counter wrap after 16 words
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb_reset();
        enable = 1'b1;
        clear_fifos();
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < ((i < 2) ? 5 : 4); r++) load(i, mk(i, 0, 8'h10*r + i));
        drive();
        tick(4'b0000, 0);
        for (int k = 0; k < 18; k++) begin
            tick(4'b0001 << (k % 4), 1);
            if (k == 17) check("wrap_0", 32'(seen_cnt), 32'd0);
        end
        tick(4'b0000, 1);
        check("wrap_1", 32'(seen_cnt), 32'd1);
        tick(4'b0000, 1);
        check("wrap_2", 32'(seen_cnt), 32'd2);

        // async reset with a push pending
        clear_fifos();
        load(0, mk(0, 3, 8'hC5));
        drive();
        tick(4'b0001, 1);
        check("push_pending_before_reset", 32'(out_push), 32'h8);
        #1 reset = 1'b1;
        #1;
        check("reset_out_push",  32'(out_push),  32'h0);
        check("reset_grant_id",  32'(grant_id),  32'h3);
        check("reset_fwd_count", 32'(fwd_count), 32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_out_data",  32'(out_data),  32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        sb_reset();
        clear_fifos();
        for (int i = 0; i < 4; i++) load(i, mk(i, 3, 8'hD0 + i));
        drive();
        tick(4'b0000, 0);
        for (int k = 0; k < 4; k++) tick(4'b0001 << k, 1);
        tick(4'b0000, 1);
        tick(4'b0000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
